// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler
//   Round-robin scheduler sharing one serial binary-to-BCD converter between
//   NUM_CHANNELS requesters. It launches one conversion at a time, waits for
//   the converter's data-valid pulse and stores each result in a per-channel
//   bank. A watchdog aborts conversions that never complete.
//
// Ports
//   i_Clock        single clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Req          level request per channel, held until that channel's o_Done
//   i_Binary       channel k operand at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   o_Conv_Binary  registered operand to the converter, stable between grants
//   o_Conv_Start   one-cycle converter start pulse
//   i_Conv_BCD     converter result
//   i_Conv_DV      converter data-valid pulse
//   o_BCD          per-channel stored results
//   o_Valid        sticky per-channel "has a result" flags
//   o_Done         one-hot, one-cycle pulse while the result is being stored
//   o_Busy         high in every state except IDLE
//   o_Error        one-cycle pulse in the last WAIT cycle of a timed-out conversion
//   o_Neg          per-channel sign of the stored result (BCD_SCHED_SIGN_MAG_EN only)
//
// Build option
//   BCD_SCHED_SIGN_MAG_EN: channel slices are two's complement. The converter
//   receives the magnitude, and the sign is kept in o_Neg.
//
// state  | meaning
// IDLE   | pick the next requester round-robin, latch its operand
// LAUNCH | o_Conv_Start high, watchdog cleared
// WAIT   | wait for i_Conv_DV or watchdog expiry
// STORE  | o_Done pulse for the granted channel
module bcd_conv_scheduler #(
  parameter int NUM_CHANNELS   = 3,
  parameter int INPUT_WIDTH    = 10,
  parameter int DECIMAL_DIGITS = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   i_Clock,
  input  logic                                   i_Reset,
  input  logic [NUM_CHANNELS-1:0]                i_Req,
  input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0]    i_Binary,
  output logic [INPUT_WIDTH-1:0]                 o_Conv_Binary,
  output logic                                   o_Conv_Start,
  input  logic [DECIMAL_DIGITS*4-1:0]            i_Conv_BCD,
  input  logic                                   i_Conv_DV,
  output logic [NUM_CHANNELS*DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic [NUM_CHANNELS-1:0]                o_Valid,
  output logic [NUM_CHANNELS-1:0]                o_Done,
  output logic                                   o_Busy,
  output logic                                   o_Error
`ifdef BCD_SCHED_SIGN_MAG_EN
  ,
  output logic [NUM_CHANNELS-1:0]                o_Neg
`endif
);

  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STORE  = 2'd3;

  logic [1:0]             r_state;
  logic [CH_W-1:0]        r_last;
  logic [CH_W-1:0]        r_ch;
  logic [WD_W-1:0]        r_wd;

  logic                   w_found;
  logic [CH_W-1:0]        w_grant;
  logic [INPUT_WIDTH-1:0] w_sel_bin;
  logic [INPUT_WIDTH-1:0] w_operand;
  logic                   w_wd_expired;

`ifdef BCD_SCHED_SIGN_MAG_EN
  logic                   r_sign;
`endif

  // Search starts one past the last grant and wraps, so a continuously
  // requesting channel cannot starve its neighbours.
  always_comb begin
    logic [CH_W-1:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CH_W'((int'(r_last) + i) % NUM_CHANNELS);
      if (!w_found && i_Req[cand]) begin
        w_found = 1'b1;
        w_grant = cand;
      end
    end
  end

  always_comb begin
    w_sel_bin = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (w_grant == CH_W'(k)) begin
        w_sel_bin = i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

`ifdef BCD_SCHED_SIGN_MAG_EN
  // The most negative value negates to itself, whose bit pattern is already
  // the correct unsigned magnitude, so no saturation is needed.
  assign w_operand = w_sel_bin[INPUT_WIDTH-1] ? (~w_sel_bin + INPUT_WIDTH'(1)) : w_sel_bin;
`else
  assign w_operand = w_sel_bin;
`endif

  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYCLES));

  assign o_Busy  = (r_state != S_IDLE);
  // Combinational so the pulse lands in the cycle WAIT exits. A data-valid
  // pulse arriving in that same cycle wins over the timeout.
  assign o_Error = (r_state == S_WAIT) && !i_Conv_DV && w_wd_expired;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state       <= S_IDLE;
      r_last        <= CH_W'(NUM_CHANNELS - 1);
      r_ch          <= '0;
      r_wd          <= '0;
      o_Conv_Binary <= '0;
      o_Conv_Start  <= 1'b0;
      o_BCD         <= '0;
      o_Valid       <= '0;
      o_Done        <= '0;
`ifdef BCD_SCHED_SIGN_MAG_EN
      r_sign        <= 1'b0;
      o_Neg         <= '0;
`endif
    end else begin
      o_Conv_Start <= 1'b0;
      o_Done       <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ch          <= w_grant;
            r_last        <= w_grant;
            o_Conv_Binary <= w_operand;
            o_Conv_Start  <= 1'b1;
`ifdef BCD_SCHED_SIGN_MAG_EN
            r_sign        <= w_sel_bin[INPUT_WIDTH-1];
`endif
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_Conv_DV) begin
            // Result, done pulse and valid flag all become visible in STORE.
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              if (r_ch == CH_W'(k)) begin
                o_BCD[k*BCD_W +: BCD_W] <= i_Conv_BCD;
                o_Done[k]               <= 1'b1;
                o_Valid[k]              <= 1'b1;
`ifdef BCD_SCHED_SIGN_MAG_EN
                o_Neg[k]                <= r_sign;
`endif
              end
            end
            r_state <= S_STORE;
          end else if (w_wd_expired) begin
            // Abort: the request stays pending and is re-arbitrated.
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_STORE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
module tb_bcd_conv_scheduler;

  localparam int NC = 3;
  localparam int IW = 10;
  localparam int DD = 4;
  localparam int TO = 255;

  logic              i_Clock = 1'b0;
  logic              i_Reset = 1'b1;
  logic [NC-1:0]     i_Req;
  logic [NC*IW-1:0]  i_Binary;
  logic [IW-1:0]     o_Conv_Binary;
  logic              o_Conv_Start;
  logic [DD*4-1:0]   i_Conv_BCD;
  logic              i_Conv_DV;
  logic [NC*DD*4-1:0] o_BCD;
  logic [NC-1:0]     o_Valid;
  logic [NC-1:0]     o_Done;
  logic              o_Busy;
  logic              o_Error;
`ifdef BCD_SCHED_SIGN_MAG_EN
  logic [NC-1:0]     o_Neg;
`endif

  bcd_conv_scheduler #(
    .NUM_CHANNELS(NC), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_Binary(i_Binary),
    .o_Conv_Binary(o_Conv_Binary), .o_Conv_Start(o_Conv_Start),
    .i_Conv_BCD(i_Conv_BCD), .i_Conv_DV(i_Conv_DV), .o_BCD(o_BCD),
    .o_Valid(o_Valid), .o_Done(o_Done), .o_Busy(o_Busy), .o_Error(o_Error)
`ifdef BCD_SCHED_SIGN_MAG_EN
    , .o_Neg(o_Neg)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    int          ch;
    logic [15:0] bcd;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] launch_log[$];
  int            total = 0;
  int            bad = 0;
  int            err_cnt = 0;
  bit            conv_en = 1'b1;
  int            stray_cnt = 0;
  int            stray_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] bin2bcd(input logic [IW-1:0] v);
    int          n;
    logic [15:0] r;
    n = int'(v);
    r = '0;
    for (int d = 0; d < DD; d++) begin
      r[d*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Converter model: DV four cycles after the start pulse.
  initial begin
    logic [IW-1:0] op;
    i_Conv_DV  = 1'b0;
    i_Conv_BCD = '0;
    forever begin
      @(negedge i_Clock);
      if (stray_done != stray_cnt) begin
        stray_done++;
        i_Conv_BCD = 16'h1234;
        i_Conv_DV  = 1'b1;
        @(negedge i_Clock);
        i_Conv_DV  = 1'b0;
      end else if (o_Conv_Start) begin
        op = o_Conv_Binary;
        launch_log.push_back(op);
        if (conv_en) begin
          repeat (3) @(negedge i_Clock);
          i_Conv_BCD = bin2bcd(op);
          i_Conv_DV  = 1'b1;
          @(negedge i_Clock);
          i_Conv_DV  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_Clock);
      if (o_Error) err_cnt++;
      if (o_Done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(o_Done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_onehot", 64'(o_Done), 64'(3'(1) << e.ch));
          chk("done_bcd", 64'(o_BCD[e.ch*16 +: 16]), 64'(e.bcd));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic do_reset();
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);
  endtask

  task automatic wait_done_ch(input int ch, input int budget, input string name);
    int n;
    n = 0;
    while (!o_Done[ch] && n < budget) begin
      @(negedge i_Clock);
      n++;
    end
    if (!o_Done[ch]) chk({name, "_done_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_start(input int budget, input string name, output int n);
    n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while (!o_Conv_Start && n < budget);
    if (!o_Conv_Start) chk({name, "_start_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    int base;
    int n;
    int dones;
    i_Req    = '0;
    i_Binary = '0;

    // Reset state
    repeat (3) @(negedge i_Clock);
    chk("rst_bcd", 64'(o_BCD), 64'(0));
    chk("rst_valid", 64'(o_Valid), 64'(0));
    chk("rst_done", 64'(o_Done), 64'(0));
    chk("rst_busy", 64'(o_Busy), 64'(0));
    chk("rst_error", 64'(o_Error), 64'(0));
    chk("rst_start", 64'(o_Conv_Start), 64'(0));
    chk("rst_conv_bin", 64'(o_Conv_Binary), 64'(0));
    i_Reset = 1'b0;
    @(negedge i_Clock);

    // Single conversion on channel 1
    base = launch_log.size();
    i_Binary[1*IW +: IW] = 10'h3E7;
    exp_q.push_back('{1, 16'h0999});
    i_Req = 3'b010;
    wait_done_ch(1, 50, "single");
    i_Req = '0;
    repeat (2) @(negedge i_Clock);
    chk("single_starts", 64'(launch_log.size() - base), 64'(1));
    chk("single_operand", 64'(launch_log[base]), 64'(10'h3E7));
    chk("single_valid", 64'(o_Valid), 64'(3'b010));
    chk("single_bcd", 64'(o_BCD[31:16]), 64'(16'h0999));
    chk("single_busy", 64'(o_Busy), 64'(0));

    // Round-robin fairness after reset
    do_reset();
    base = launch_log.size();
    i_Binary = {10'd3, 10'd2, 10'd1};
    for (int i = 0; i < 6; i++) exp_q.push_back('{i % 3, 16'(i % 3 + 1)});
    i_Req = 3'b111;
    n = 0;
    dones = 0;
    while (dones < 6 && n < 500) begin
      @(negedge i_Clock);
      n++;
      if (o_Done != '0) dones++;
    end
    i_Req = '0;
    if (dones < 6) chk("rr_done_timeout", 64'(dones), 64'(6));
    repeat (3) @(negedge i_Clock);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(launch_log[base + i]), 64'(i % 3 + 1));
    end
    chk("rr_bcd", 64'(o_BCD), 64'(48'h0003_0002_0001));
    chk("rr_valid", 64'(o_Valid), 64'(3'b111));

    // Watchdog timeout on channel 0, then relaunch
    conv_en = 1'b0;
    base = launch_log.size();
    i_Binary[0 +: IW] = 10'd7;
    i_Req = 3'b001;
    wait_start(20, "to", n);
    n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while (!o_Error && n < 400);
    chk("to_wait_cycles", 64'(n), 64'(TO + 1));
    conv_en = 1'b1;
    exp_q.push_back('{0, 16'h0007});
    wait_start(20, "to_relaunch", n);
    chk("to_relaunch_gap", 64'(n), 64'(2));
    wait_done_ch(0, 50, "to");
    i_Req = '0;
    repeat (3) @(negedge i_Clock);
    chk("to_err_cnt", 64'(err_cnt), 64'(1));
    chk("to_launches", 64'(launch_log.size() - base), 64'(2));
    chk("to_operand", 64'(launch_log[base + 1]), 64'(7));

    // Stray data-valid in IDLE
    stray_cnt++;
    repeat (4) @(negedge i_Clock);
    chk("stray_bcd", 64'(o_BCD), 64'(48'h0003_0002_0007));
    chk("stray_valid", 64'(o_Valid), 64'(3'b111));
    chk("stray_busy", 64'(o_Busy), 64'(0));

`ifdef BCD_SCHED_SIGN_MAG_EN
    // Signed inputs on channel 2
    base = launch_log.size();
    i_Binary[2*IW +: IW] = 10'h200;
    exp_q.push_back('{2, 16'h0512});
    i_Req = 3'b100;
    wait_done_ch(2, 50, "neg512");
    i_Req = '0;
    repeat (2) @(negedge i_Clock);
    chk("neg512_operand", 64'(launch_log[base]), 64'(512));
    chk("neg512_sign", 64'(o_Neg), 64'(3'b100));
    i_Binary[2*IW +: IW] = 10'h3FF;
    exp_q.push_back('{2, 16'h0001});
    i_Req = 3'b100;
    wait_done_ch(2, 50, "neg1");
    i_Req = '0;
    repeat (2) @(negedge i_Clock);
    chk("neg1_operand", 64'(launch_log[base + 1]), 64'(1));
    chk("neg1_sign", 64'(o_Neg), 64'(3'b100));
`endif

    // Reset during WAIT, then a late DV from the interrupted conversion
    base = launch_log.size();
    i_Binary[1*IW +: IW] = 10'd42;
    i_Req = 3'b010;
    wait_start(20, "midrst", n);
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b1;
    i_Req = '0;
    #1;
    chk("midrst_bcd", 64'(o_BCD), 64'(0));
    chk("midrst_valid", 64'(o_Valid), 64'(0));
    chk("midrst_busy", 64'(o_Busy), 64'(0));
    chk("midrst_conv_bin", 64'(o_Conv_Binary), 64'(0));
    @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (8) @(negedge i_Clock);
    chk("late_dv_bcd", 64'(o_BCD), 64'(0));
    chk("late_dv_valid", 64'(o_Valid), 64'(0));
    chk("late_dv_busy", 64'(o_Busy), 64'(0));
    chk("late_dv_launches", 64'(launch_log.size() - base), 64'(1));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Round-robin scheduler that shares one serial binary-to-BCD converter between `NUM_CHANNELS` requesters, such as the X/Y/Z accelerometer axes feeding the 7-segment display path. It does the following:
- arbitrates among the requesters;
- launches one conversion at a time with a single-cycle start pulse;
- waits for the converter's data-valid pulse;
- stores each result in a per-channel register bank that the display mux reads.

A watchdog recovers from lost or hung conversions.

## Interface
Parameters:
- `NUM_CHANNELS`, 3: number of requesters (2..8).
- `INPUT_WIDTH`, 10: binary width per channel; must equal the converter's `INPUT_WIDTH`.
- `DECIMAL_DIGITS`, 4: BCD digits per result; must equal the converter's `DECIMAL_DIGITS`.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles in WAIT before abort; must exceed the worst-case conversion time.

Ports:
- `i_Clock`, in, 1: single clock; all logic is on its rising edge.
- `i_Reset`, in, 1: asynchronous, active-high reset.
- `i_Req`, in, `NUM_CHANNELS`: level request per channel; held until that channel's `o_Done` pulse.
- `i_Binary`, in, `NUM_CHANNELS*INPUT_WIDTH`: channel k's value occupies bits `[k*INPUT_WIDTH +: INPUT_WIDTH]`.
- `o_Conv_Binary`, out, `INPUT_WIDTH`: operand to the converter; registered and stable from the grant until the next grant.
- `o_Conv_Start`, out, 1: one-cycle start pulse to the converter.
- `i_Conv_BCD`, in, `DECIMAL_DIGITS*4`: converter result.
- `i_Conv_DV`, in, 1: converter data-valid pulse.
- `o_BCD`, out, `NUM_CHANNELS*DECIMAL_DIGITS*4`: per-channel stored results.
- `o_Valid`, out, `NUM_CHANNELS`: sticky; set on the channel's first stored result.
- `o_Done`, out, `NUM_CHANNELS`: one-cycle pulse, one-hot, on the cycle after a store.
- `o_Busy`, out, 1: high in every state except IDLE.
- `o_Error`, out, 1: one-cycle pulse on watchdog timeout.

## Operation
- **States:** IDLE, LAUNCH, WAIT, STORE.
- **IDLE:**
  - If `i_Req` is nonzero, grant the first requesting channel at or after `r_Last+1`, searching upward modulo `NUM_CHANNELS`.
  - Latch that channel's slice into `o_Conv_Binary`.
  - Record the channel index, set `r_Last` to it, and go to LAUNCH.
- **LAUNCH:** drive `o_Conv_Start` high for this cycle only, clear the watchdog, and go to WAIT.
- **WAIT:**
  - On `i_Conv_DV`, capture `i_Conv_BCD` into the granted channel's slice of `o_BCD` and go to STORE.
  - Otherwise increment the watchdog.
  - When the watchdog equals `TIMEOUT_CYCLES`, pulse `o_Error` and go to IDLE. The channel's stored result and `o_Valid` are unchanged, no `o_Done` is issued, and the request stays pending.
- **STORE:** pulse `o_Done` for the granted channel, set its `o_Valid` bit, and go to IDLE.
- **Stray data-valid:** `i_Conv_DV` outside WAIT is ignored. This covers a DV still arriving from a conversion that a reset interrupted.
- **Arbitration:** round-robin only. With all channels requesting continuously, the grant order is 0,1,2,0,… after reset, because `r_Last` resets to `NUM_CHANNELS-1`.
- **Request handling:** a request that drops before its grant is never granted. A request still high in the cycle after its `o_Done` is treated as a new request.
- **Storage:** `o_BCD` slices hold their value until overwritten by the same channel.

## Timing
- **Reset values** (all registers reset asynchronously):
  - all outputs are 0;
  - state is IDLE;
  - `r_Last` is `NUM_CHANNELS-1`;
  - the watchdog is 0.
- **Reset mid-operation:** returns to IDLE immediately. The result being converted is discarded.
- **Request to start:** request sampled in IDLE at cycle N, then LAUNCH at N+1 with `o_Conv_Start` high during N+1, then WAIT from N+2.
- **Data-valid to done:** DV sampled high in WAIT at cycle M, then `o_BCD` updated and STORE at M+1 with `o_Done` high during M+1, then IDLE at M+2.
- **Back-to-back:** the next `o_Conv_Start` comes no earlier than M+3. This guarantees the converter has returned to its idle state.
- **Timeout:** `o_Error` is high in the cycle where WAIT exits. IDLE follows in the next cycle.
- **Watchdog counter:** width is `$clog2(TIMEOUT_CYCLES+1)`. It never wraps.

## Configuration
`BCD_SCHED_SIGN_MAG_EN` adds signed-input handling.
- **Defined:**
  - Channel slices are two's complement.
  - At grant, `o_Conv_Binary` is the unsigned magnitude: the value itself if the MSB is 0, otherwise its negation. For the most negative value, 1000000000 (−512) gives a magnitude of 512, which is representable unsigned, so no saturation is applied.
  - An extra output `o_Neg` (out, `NUM_CHANNELS`, reset 0) holds each channel's sign bit and updates in the same cycle as that channel's `o_BCD` slice.
- **Undefined:** slices are unsigned and pass through unmodified, and `o_Neg` does not exist.

## Test plan
- **Single conversion:** after reset, channel 1 requests with value 0x3E7 (999) and the bench converter model runs normally. Expect one `o_Conv_Start` pulse, `o_Conv_Binary`=0x3E7, channel 1's `o_BCD` slice = 0x0999, `o_Done`=3'b010 for one cycle, and `o_Valid`=3'b010.
- **Round-robin fairness:** all three channels request continuously with values 1, 2 and 3. Expect the first six grants to be 0,1,2,0,1,2, and `o_BCD` = 0x0003_0002_0001.
- **Timeout:** request channel 0 with the converter model never asserting DV and `TIMEOUT_CYCLES`=255. Expect `o_Error` to pulse after 255 WAIT cycles, no `o_Done`, then a relaunch of channel 0.
- **Reset mid-conversion:** assert `i_Reset` while in WAIT, then let the model emit a late DV. Expect all outputs to be 0 and `o_BCD` untouched by the late DV.
- **Signed input (with `BCD_SCHED_SIGN_MAG_EN`):**
  - channel 2 = 0x200 (−512) gives `o_Conv_Binary`=512, BCD 0x0512 and `o_Neg[2]`=1;
  - channel 2 = 0x3FF (−1) gives BCD 0x0001 and `o_Neg[2]`=1.
- **Stray data-valid:** pulse `i_Conv_DV` in IDLE with `i_Conv_BCD`=0x1234. Expect no change to `o_BCD`, `o_Done` or `o_Valid`.
